instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq.sv | 149 ++++++++++++++
 tb/tb_instr_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq.sv
// instr_seq : fetches instruction words from program memory and issues them to
// a decoder. It is a five-state sequencer (IDLE, FETCH, WAIT, EXEC, HALTED)
// with a program counter, an instruction register and a saturating issue counter.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   run request, honoured only in IDLE and HALTED
//   mem_rd       out  program-memory read strobe (FETCH only)
//   mem_addr     out  program-memory read address (= pc)
//   mem_rdata    in   read data, valid the cycle after mem_rd
//   dec_enable   out  instruction valid to the decoder
//   dec_value    out  instruction word to the decoder (holds its last issued word)
//   dec_ready    in   decoder accepts dec_value this cycle
//   busy         out  high in FETCH, WAIT or EXEC
//   halted       out  high in HALTED
//   issue_count  out  number of words handed to the decoder, saturating at 255
module instr_seq #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               mem_rd,
  output logic [ADDRESS_BITS-1:0]            mem_addr,
  input  logic [INSTR_BITS+ADDRESS_BITS-1:0] mem_rdata,
  output logic                               dec_enable,
  output logic [INSTR_BITS+ADDRESS_BITS-1:0] dec_value,
  input  logic                               dec_ready,
  output logic                               busy,
  output logic                               halted,
  output logic [7:0]                         issue_count
);

  localparam int W = INSTR_BITS + ADDRESS_BITS;

  localparam logic [INSTR_BITS-1:0] OP_NOP  = '0;
  localparam logic [INSTR_BITS-1:0] OP_JMP  = INSTR_BITS'(3);
  localparam logic [INSTR_BITS-1:0] OP_HALT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [W-1:0]            ir_q, ir_d;
  logic [W-1:0]            dv_q, dv_d;
  logic [7:0]              cnt_q, cnt_d;

  logic [INSTR_BITS-1:0]   opcode;
  logic [ADDRESS_BITS-1:0] operand;

  function automatic logic is_issue(input logic [INSTR_BITS-1:0] op);
    return (op != OP_NOP) && (op != OP_JMP) && (op != OP_HALT);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign opcode  = ir_q[W-1:ADDRESS_BITS];
  assign operand = ir_q[ADDRESS_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    dv_d       = dv_q;
    cnt_d      = cnt_q;
    mem_rd     = 1'b0;
    dec_enable = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        ir_d = mem_rdata;
        // The decoder-facing word only changes for words that will be issued,
        // so dec_value keeps the last issued word across NOP/JMP/HALT.
        if (is_issue(mem_rdata[W-1:ADDRESS_BITS])) begin
          dv_d = mem_rdata;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode == OP_NOP) begin
          pc_d    = pc_q + ADDRESS_BITS'(1);
          state_d = S_FETCH;
        end else if (opcode == OP_JMP) begin
          pc_d    = operand;
          state_d = S_FETCH;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          dec_enable = 1'b1;
          if (dec_ready) begin
            pc_d    = pc_q + ADDRESS_BITS'(1);
            cnt_d   = sat_inc(cnt_q);
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr    = pc_q;
  assign dec_value   = dv_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EXEC);
  assign halted      = (state_q == S_HALTED);
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_instr_seq.sv
module tb_instr_seq;

  localparam int MAXC = 2000;

  logic       clk, rst, start, dec_ready;
  logic       mem_rd, dec_enable, busy, halted;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata, dec_value, issue_count;

  logic [7:0] mem [0:31];
  int         stall_tab [0:511];

  // Expected per-cycle outputs {mem_rd, mem_addr, dec_enable, dec_value, busy, halted, issue_count}
  logic [24:0] e_vec  [0:MAXC];
  bit          e_en   [0:MAXC];
  bit          e_acc  [0:MAXC];
  bit          e_busy [0:MAXC];

  int         g_ncyc;
  int         m_cnt;
  logic [7:0] m_dv;
  bit         m_halted;

  int         checks = 0;
  int         passes = 0;
  int         obs_fetch, obs_en;
  logic [4:0] obs_addr [0:2];

  instr_seq #(.ADDRESS_BITS(5), .INSTR_BITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .dec_enable  (dec_enable),
    .dec_value   (dec_value),
    .dec_ready   (dec_ready),
    .busy        (busy),
    .halted      (halted),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic put(input int c, input bit rd, input logic [4:0] a, input bit en,
                     input bit acc, input bit bsy, input bit hl);
    if (c <= g_ncyc) begin
      e_vec[c]  = {rd, a, en, m_dv, bsy, hl, 8'(m_cnt)};
      e_en[c]   = en;
      e_acc[c]  = acc;
      e_busy[c] = bsy;
    end
  endtask

  // Walks the program one instruction at a time: fetch and wait take one cycle
  // each, execute takes one cycle plus the decoder stall for issued words.
  task automatic build_model(input int ncyc);
    int         c, k;
    logic [4:0] pc;
    logic [7:0] w;
    logic [2:0] op;
    g_ncyc = ncyc;
    c = 1; k = 0; pc = 5'd0;
    if (m_halted) m_cnt = 0;
    m_halted = 1'b0;
    while (c <= ncyc) begin
      w  = mem[pc];
      op = w[7:5];
      put(c, 1, pc, 0, 0, 1, 0); c++;
      put(c, 0, pc, 0, 0, 1, 0); c++;
      if (op == 3'd7) begin
        put(c, 0, pc, 0, 0, 1, 0); c++;
        while (c <= ncyc) begin
          put(c, 0, pc, 0, 0, 0, 1); c++;
        end
        m_halted = 1'b1;
      end else if (op == 3'd0) begin
        put(c, 0, pc, 0, 0, 1, 0); c++;
        pc = 5'((int'(pc) + 1) % 32);
      end else if (op == 3'd3) begin
        put(c, 0, pc, 0, 0, 1, 0); c++;
        pc = w[4:0];
      end else begin
        m_dv = w;
        for (int s = 0; s < stall_tab[k]; s++) begin
          put(c, 0, pc, 1, 0, 1, 0); c++;
        end
        put(c, 0, pc, 1, 1, 1, 0); c++;
        k++;
        pc = 5'((int'(pc) + 1) % 32);
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  endtask

  task automatic run_prog(input int ncyc, input bit noise, input string tag);
    logic [24:0] got;
    build_model(ncyc);
    obs_fetch = 0; obs_en = 0;
    for (int i = 0; i < 3; i++) obs_addr[i] = 5'h1F;
    @(negedge clk);
    start     = 1'b1;
    dec_ready = 1'($urandom_range(0, 1));
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      got = {mem_rd, mem_addr, dec_enable, dec_value, busy, halted, issue_count};
      checks++;
      if (got !== e_vec[c])
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, e_vec[c]);
      else
        passes++;
      if (mem_rd) begin
        if (obs_fetch < 3) obs_addr[obs_fetch] = mem_addr;
        obs_fetch++;
      end
      if (dec_enable) obs_en++;
      start     = (noise && e_busy[c]) ? 1'($urandom_range(0, 1)) : 1'b0;
      dec_ready = e_en[c] ? e_acc[c] : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; dec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_dv = 8'h00; m_halted = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] got;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 got = {mem_rd, mem_addr, dec_enable, dec_value, busy, halted, issue_count};
    checks++;
    if (got !== 25'd0) $display("FAIL reset_async got=%h exp=%h", got, 25'd0);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_dv = 8'h00; m_halted = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dec_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      got = {mem_rd, mem_addr, dec_enable, dec_value, busy, halted, issue_count};
      checks++;
      if (got !== 25'd0) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, 25'd0);
      else passes++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h25; mem[1] = 8'h4A; mem[2] = 8'hE0;
    for (int i = 0; i < 512; i++) stall_tab[i] = 0;
    run_prog(12, 1'b0, "basic");
    checks++;
    if (halted !== 1'b1) $display("FAIL basic_halted got=%b exp=1", halted);
    else passes++;
    checks++;
    if (issue_count !== 8'd2) $display("FAIL basic_count got=%0d exp=2", issue_count);
    else passes++;
  endtask

  task automatic test_stall();
    mem[0] = 8'h25; mem[1] = 8'hE0;
    stall_tab[0] = 5;
    run_prog(14, 1'b1, "stall");
    checks++;
    if (obs_en !== 6) $display("FAIL stall_en_cycles got=%0d exp=6", obs_en);
    else passes++;
    checks++;
    if (issue_count !== 8'd1) $display("FAIL stall_count got=%0d exp=1", issue_count);
    else passes++;
    stall_tab[0] = 0;
  endtask

  task automatic test_nop();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hE0;
    run_prog(16, 1'b1, "nop");
    checks++;
    if (obs_fetch !== 4) $display("FAIL nop_fetches got=%0d exp=4", obs_fetch);
    else passes++;
    checks++;
    if (obs_en !== 0) $display("FAIL nop_enables got=%0d exp=0", obs_en);
    else passes++;
    checks++;
    if ({halted, issue_count} !== 9'h100)
      $display("FAIL nop_end got=%h exp=%h", {halted, issue_count}, 9'h100);
    else passes++;
  endtask

  task automatic test_jmp_wrap();
    mem[0] = 8'h7F; mem[31] = 8'h21;
    for (int i = 0; i < 512; i++) stall_tab[i] = $urandom_range(0, 3);
    run_prog(40, 1'b1, "jmp_wrap");
    checks++;
    if ({obs_addr[0], obs_addr[1], obs_addr[2]} !== {5'd0, 5'd31, 5'd0})
      $display("FAIL jmp_wrap_addrs got=%0d,%0d,%0d exp=0,31,0",
               obs_addr[0], obs_addr[1], obs_addr[2]);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [24:0] got;
    do_reset();
    mem[0] = 8'h25; mem[1] = 8'h4A;
    stall_tab[0] = 0; stall_tab[1] = 100;
    run_prog(7, 1'b0, "reset_mid_pre");
    #2 rst = 1'b1;
    #1 got = {mem_rd, mem_addr, dec_enable, dec_value, busy, halted, issue_count};
    checks++;
    if (got !== 25'd0) $display("FAIL reset_mid_drop got=%h exp=%h", got, 25'd0);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_dv = 8'h00; m_halted = 1'b0;
    mem[0] = 8'hE0;
    run_prog(6, 1'b0, "reset_mid_restart");
    checks++;
    if (obs_addr[0] !== 5'd0) $display("FAIL reset_mid_addr got=%0d exp=0", obs_addr[0]);
    else passes++;
  endtask

  task automatic test_saturate();
    do_reset();
    mem[0] = 8'h21; mem[1] = 8'h60;
    for (int i = 0; i < 512; i++) stall_tab[i] = 0;
    run_prog(1850, 1'b1, "saturate");
    checks++;
    if (issue_count !== 8'd255) $display("FAIL saturate_count got=%0d exp=255", issue_count);
    else passes++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 512; i++) stall_tab[i] = $urandom_range(0, 3);
      run_prog(300, 1'b1, "random");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dec_ready = 1'b0;
    m_cnt = 0; m_dv = 8'h00; m_halted = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 512; i++) stall_tab[i] = 0;
    test_reset();
    test_basic();
    test_stall();
    test_nop();
    test_jmp_wrap();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
